// File: rtl/sipo_pkg.sv
// ============================================================================
// Module      : sipo_pkg
// Description : Shared state encoding and sizing helper for sipo_shift_reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } sipo_state_e;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int sipo_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_bit_counter.sv
// ============================================================================
// Module      : sipo_bit_counter
// Description : Received-bit counter with clear/load-one/increment and a
//               flag marking that the next accepted bit completes the word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_load,
    input  logic i_inc,
    output logic o_last
);

    localparam int CW = sipo_cnt_width(WIDTH);
    localparam logic [CW-1:0] C_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_load) begin
            count_d = CW'(1);
        end else if (i_inc && (count_q != C_MAX)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_last = (count_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/sipo_shift_reg.sv
// ============================================================================
// Module      : sipo_shift_reg
// Description : Serial-in/parallel-out shift register with one-cycle Valid
//               strobe and zero-dead-cycle back-to-back words.
//               Optional even-parity check enabled by macro SIPO_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_shift_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             Cp,
    input  logic             Rst,
    input  logic             D,
    input  logic             En,
    input  logic             Clr,
    output logic [WIDTH-1:0] Q,
    output logic             Valid,
    output logic             Busy
`ifdef SIPO_PARITY_EN
    ,
    output logic             Par_err
`endif
);

    sipo_state_e      state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] w_shifted;
    logic             w_cnt_clr;
    logic             w_cnt_load;
    logic             w_cnt_inc;
    logic             w_cnt_last;
`ifdef SIPO_PARITY_EN
    logic             par_err_q, par_err_d;
`endif

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shifted = {sr_q[WIDTH-2:0], D};
        end else begin : g_lsb_first
            assign w_shifted = {D, sr_q[WIDTH-1:1]};
        end
    endgenerate

    sipo_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (Cp),
        .rst    (Rst),
        .i_clr  (w_cnt_clr),
        .i_load (w_cnt_load),
        .i_inc  (w_cnt_inc),
        .o_last (w_cnt_last)
    );

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        q_d        = q_q;
        w_cnt_clr  = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_inc  = 1'b0;
`ifdef SIPO_PARITY_EN
        par_err_d  = par_err_q;
`endif
        if (Clr) begin
            // Abort wins over En; blocking DONE entry also suppresses Valid.
            state_d   = IDLE;
            w_cnt_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (En) begin
                        sr_d       = w_shifted;
                        w_cnt_load = 1'b1;
                        state_d    = SHIFT;
                    end else begin
                        w_cnt_clr  = 1'b1;
                        state_d    = IDLE;
                    end
                end
                SHIFT: begin
                    if (En) begin
                        sr_d      = w_shifted;
                        w_cnt_inc = 1'b1;
                        if (w_cnt_last) begin
`ifdef SIPO_PARITY_EN
                            state_d = PARITY;
`else
                            q_d     = w_shifted;
                            state_d = DONE;
`endif
                        end
                    end
                end
`ifdef SIPO_PARITY_EN
                PARITY: begin
                    // Parity bit is checked but never shifted into the word.
                    if (En) begin
                        q_d       = sr_q;
                        par_err_d = (^sr_q) ^ D;
                        state_d   = DONE;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Cp or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            q_q       <= '0;
`ifdef SIPO_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            q_q       <= q_d;
`ifdef SIPO_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign Q     = q_q;
    assign Valid = (state_q == DONE);
    assign Busy  = (state_q == SHIFT) || (state_q == PARITY);
`ifdef SIPO_PARITY_EN
    assign Par_err = par_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sipo_shift_reg.sv
// ============================================================================
// Module      : tb_sipo_shift_reg
// Description : Scoreboard bench driving an MSB-first and an LSB-first
//               instance from the same serial stream (SIPO_PARITY_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sipo_shift_reg;

    localparam int W = 8;
`ifdef SIPO_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         Cp  = 1'b0;
    logic         Rst = 1'b1;
    logic         D   = 1'b0;
    logic         En  = 1'b0;
    logic         Clr = 1'b0;
    logic [W-1:0] q_m, q_l;
    logic         v_m, v_l, b_m, b_l;
`ifdef SIPO_PARITY_EN
    logic         pe_m, pe_l;
`endif

    sipo_shift_reg #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
        .Cp(Cp), .Rst(Rst), .D(D), .En(En), .Clr(Clr),
        .Q(q_m), .Valid(v_m), .Busy(b_m)
`ifdef SIPO_PARITY_EN
        , .Par_err(pe_m)
`endif
    );

    sipo_shift_reg #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .Cp(Cp), .Rst(Rst), .D(D), .En(En), .Clr(Clr),
        .Q(q_l), .Valid(v_l), .Busy(b_l)
`ifdef SIPO_PARITY_EN
        , .Par_err(pe_l)
`endif
    );

    always #5 Cp = ~Cp;

    int           n_tests = 0;
    int           n_fail  = 0;

    // Reference model and scoreboard
    logic [W-1:0] sb_msb[$];
    logic [W-1:0] sb_lsb[$];
    logic         sb_par[$];
    int           m_cnt = 0;
    logic [W-1:0] m_msb = '0;
    logic [W-1:0] m_lsb = '0;
    logic [W-1:0] last_m = '0;
    logic [W-1:0] last_l = '0;

    function automatic logic fbit(input logic [W-1:0] w, input int i);
        return (i < W) ? w[W-1-i] : ^w;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_msb  = '0;
        m_lsb  = '0;
        last_m = '0;
        last_l = '0;
        sb_msb.delete();
        sb_lsb.delete();
        sb_par.delete();
    endtask

    // Drive one cycle, advance the model, report whether Valid is due.
    task automatic step(input logic en, input logic d, input logic clr, output logic exp_v);
        En  = en;
        D   = d;
        Clr = clr;
        @(posedge Cp);
        #1;
        exp_v = 1'b0;
        if (clr) begin
            m_cnt = 0;
        end else if (en) begin
            if (m_cnt < W) begin
                m_msb = {m_msb[W-2:0], d};
                m_lsb = {d, m_lsb[W-1:1]};
            end
            m_cnt++;
            if (m_cnt == FRAME) begin
                sb_msb.push_back(m_msb);
                sb_lsb.push_back(m_lsb);
                sb_par.push_back((FRAME > W) ? ((^m_msb) ^ d) : 1'b0);
                m_cnt = 0;
                exp_v = 1'b1;
            end
        end
        En  = 1'b0;
        Clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Cp);
        #1;
        n_tests++;
        if (q_m !== '0 || q_l !== '0 || v_m !== 1'b0 || b_m !== 1'b0 || v_l !== 1'b0 || b_l !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: Q=%h/%h Valid=%b/%b Busy=%b/%b, want 00/00 0/0 0/0", q_m, q_l, v_m, v_l, b_m, b_l);
        end
        Rst = 1'b0;
        model_reset();
    endtask

    task automatic test_msb_lsb();
        logic ev;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, fbit(8'hB2, i), 1'b0, ev);
            n_tests++;
            if (v_m !== ev || v_l !== ev) begin
                n_fail++;
                $display("FAIL basic_valid bit%0d: Valid=%b/%b, want %b", i, v_m, v_l, ev);
            end
            if (ev) begin
                last_m = sb_msb.pop_front();
                last_l = sb_lsb.pop_front();
                void'(sb_par.pop_front());
            end
        end
        n_tests++;
        if (q_m !== 8'hB2 || q_l !== 8'h4D || b_m !== 1'b0 || b_l !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_word: Q=%h/%h Busy=%b/%b, want B2/4D 0/0", q_m, q_l, b_m, b_l);
        end
        step(1'b0, 1'b0, 1'b0, ev);
        n_tests++;
        if (v_m !== 1'b0 || v_l !== 1'b0 || q_m !== last_m || q_l !== last_l) begin
            n_fail++;
            $display("FAIL basic_hold: Valid=%b/%b Q=%h/%h, want 0/0 %h/%h", v_m, v_l, q_m, q_l, last_m, last_l);
        end
    endtask

    task automatic test_back_to_back();
        logic         ev;
        logic [W-1:0] words [2];
        words[0] = 8'hA5;
        words[1] = 8'h3C;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < FRAME; i++) begin
                step(1'b1, fbit(words[w], i), 1'b0, ev);
                n_tests++;
                if (v_m !== ev || v_l !== ev || b_m !== !ev || b_l !== !ev) begin
                    n_fail++;
                    $display("FAIL b2b_strobe w%0d bit%0d: Valid=%b/%b Busy=%b/%b, want %b %b", w, i, v_m, v_l, b_m, b_l, ev, !ev);
                end
                if (ev) begin
                    last_m = sb_msb.pop_front();
                    last_l = sb_lsb.pop_front();
                    void'(sb_par.pop_front());
                    n_tests++;
                    if (q_m !== last_m || q_l !== last_l || q_m !== words[w]) begin
                        n_fail++;
                        $display("FAIL b2b_word w%0d: Q=%h/%h, want %h/%h", w, q_m, q_l, last_m, last_l);
                    end
                end
            end
        end
        step(1'b0, 1'b0, 1'b0, ev);
        n_tests++;
        if (v_m !== 1'b0 || b_m !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: Valid=%b Busy=%b, want 0 0", v_m, b_m);
        end
    endtask

    task automatic test_reset_mid_word();
        logic ev;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, ev);
        #2;
        Rst = 1'b1;
        #1;
        n_tests++;
        if (q_m !== '0 || q_l !== '0 || v_m !== 1'b0 || b_m !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: Q=%h/%h Valid=%b Busy=%b, want 00/00 0 0", q_m, q_l, v_m, b_m);
        end
        @(posedge Cp);
        #1;
        Rst = 1'b0;
        model_reset();
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, fbit(8'h96, i), 1'b0, ev);
            n_tests++;
            if (v_m !== ev || v_l !== ev) begin
                n_fail++;
                $display("FAIL rst_fresh_valid bit%0d: Valid=%b/%b, want %b", i, v_m, v_l, ev);
            end
            if (ev) begin
                last_m = sb_msb.pop_front();
                last_l = sb_lsb.pop_front();
                void'(sb_par.pop_front());
                n_tests++;
                if (q_m !== 8'h96 || q_l !== last_l) begin
                    n_fail++;
                    $display("FAIL rst_fresh_word: Q=%h/%h, want 96/%h", q_m, q_l, last_l);
                end
            end
        end
        step(1'b0, 1'b0, 1'b0, ev);
    endtask

    task automatic test_clr();
        logic ev;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, ev);
        step(1'b1, 1'b1, 1'b1, ev);
        n_tests++;
        if (v_m !== 1'b0 || b_m !== 1'b0 || b_l !== 1'b0 || q_m !== last_m || q_l !== last_l) begin
            n_fail++;
            $display("FAIL clr_abort: Valid=%b Busy=%b/%b Q=%h/%h, want 0 0/0 %h/%h", v_m, b_m, b_l, q_m, q_l, last_m, last_l);
        end
        // Clr on the edge that would complete the frame must swallow Valid.
        for (int i = 0; i < FRAME - 1; i++) step(1'b1, 1'b1, 1'b0, ev);
        step(1'b1, 1'b1, 1'b1, ev);
        step(1'b0, 1'b0, 1'b0, ev);
        n_tests++;
        if (v_m !== 1'b0 || v_l !== 1'b0 || q_m !== last_m) begin
            n_fail++;
            $display("FAIL clr_suppress: Valid=%b/%b Q=%h, want 0/0 %h", v_m, v_l, q_m, last_m);
        end
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, fbit(8'hFF, i), 1'b0, ev);
            n_tests++;
            if (v_m !== ev || v_l !== ev) begin
                n_fail++;
                $display("FAIL clr_gap_valid bit%0d: Valid=%b/%b, want %b", i, v_m, v_l, ev);
            end
            if (ev) begin
                last_m = sb_msb.pop_front();
                last_l = sb_lsb.pop_front();
                void'(sb_par.pop_front());
                n_tests++;
                if (q_m !== 8'hFF || q_l !== last_l) begin
                    n_fail++;
                    $display("FAIL clr_gap_word: Q=%h/%h, want FF/%h", q_m, q_l, last_l);
                end
            end else begin
                step(1'b0, 1'b0, 1'b0, ev);
                n_tests++;
                if (v_m !== 1'b0 || b_m !== 1'b1 || q_m !== last_m || q_l !== last_l) begin
                    n_fail++;
                    $display("FAIL clr_gap_hold bit%0d: Valid=%b Busy=%b Q=%h/%h, want 0 1 %h/%h", i, v_m, b_m, q_m, q_l, last_m, last_l);
                end
            end
        end
        step(1'b0, 1'b0, 1'b0, ev);
    endtask

`ifdef SIPO_PARITY_EN
    task automatic test_parity();
        logic ev;
        logic ep;
        logic pbits [2];
        logic want_pe [2];
        pbits[0] = 1'b1; want_pe[0] = 1'b0;
        pbits[1] = 1'b0; want_pe[1] = 1'b1;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < FRAME; i++) begin
                step(1'b1, (i < W) ? fbit(8'h07, i) : pbits[w], 1'b0, ev);
                n_tests++;
                if (v_m !== ev || v_l !== ev) begin
                    n_fail++;
                    $display("FAIL par_valid w%0d bit%0d: Valid=%b/%b, want %b", w, i, v_m, v_l, ev);
                end
                if (ev) begin
                    last_m = sb_msb.pop_front();
                    last_l = sb_lsb.pop_front();
                    ep     = sb_par.pop_front();
                    n_tests++;
                    if (q_m !== 8'h07 || q_l !== last_l || pe_m !== ep || pe_l !== ep || pe_m !== want_pe[w]) begin
                        n_fail++;
                        $display("FAIL par_word w%0d: Q=%h/%h Par_err=%b/%b, want 07/%h %b", w, q_m, q_l, pe_m, pe_l, last_l, ep);
                    end
                end
            end
            step(1'b0, 1'b0, 1'b0, ev);
            n_tests++;
            if (v_m !== 1'b0 || pe_m !== want_pe[w]) begin
                n_fail++;
                $display("FAIL par_hold w%0d: Valid=%b Par_err=%b, want 0 %b", w, v_m, pe_m, want_pe[w]);
            end
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_msb_lsb();
        test_back_to_back();
        test_reset_mid_word();
        test_clr();
`ifdef SIPO_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
